// File: rtl/ap_accumulator.sv
// ---------------------------------------------------------------------------
// ap_accumulator
//   Sequential saturating accumulator. It consumes a stream of signed
//   fixed-point products and returns one saturated dot-product sum per job.
//   Each accepted term performs one W-bit saturating add, clamping to the
//   signed max/min the same way ap_adder does.
//
//   Optional feature (macro AP_ACC_SAT_FLAG_EN):
//     When defined, the block adds output sat_flag. The flag is cleared on
//     start, set by any clamping step, held through DONE and cleared by
//     reset. When the macro is undefined, the port and its logic are absent.
//     The arithmetic is identical in both builds.
//
// Handshakes (all of them):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   A producer holds valid and its data stable until that transfer happens.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      synchronous active-low reset
//   start      in   1      start pulse; honoured only in IDLE
//   len        in   LEN_W  number of terms in the job; sampled on start
//   in_valid   in   1      in_data valid
//   in_data    in   W      signed term
//   in_ready   out  1      high in ACC
//   out_valid  out  1      high in DONE; held until accepted
//   out_data   out  W      saturated signed sum (the accumulator register)
//   out_ready  in   1      result accepted when out_valid & out_ready
//   busy       out  1      high in ACC or DONE
//   sat_flag   out  1      (AP_ACC_SAT_FLAG_EN only) a step in this job clamped
// ---------------------------------------------------------------------------
module ap_accumulator #(
  parameter int W     = 68,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  input  logic             out_ready,
  output logic             busy
`ifdef AP_ACC_SAT_FLAG_EN
  ,
  output logic             sat_flag
`endif
);

  localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // The FSM state is kept in a named signal so that checkers can observe it.
  state_t           state;
  logic [W-1:0]     acc;
  logic [LEN_W-1:0] cnt;

  // Saturating add. The raw sum wraps mod 2^W. Overflow can only happen
  // when both operands have the same sign and the result sign differs.
  logic [W-1:0] raw_sum;
  logic [W-1:0] sum_sat;
  logic         pos_ovf;
  logic         neg_ovf;
  logic         beat;

  assign raw_sum = acc + in_data;
  assign pos_ovf = ~acc[W-1] & ~in_data[W-1] &  raw_sum[W-1];
  assign neg_ovf =  acc[W-1] &  in_data[W-1] & ~raw_sum[W-1];
  assign sum_sat = pos_ovf ? SAT_MAX : (neg_ovf ? SAT_MIN : raw_sum);
  assign beat    = (state == S_ACC) & in_valid;

  // All outputs are decodes of registers only; nothing reaches them
  // combinationally from in_data.
  assign in_ready  = (state == S_ACC);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign out_data  = acc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            acc   <= '0;
            cnt   <= len;
            // An empty job goes straight to DONE with a zero sum.
            state <= (len == '0) ? S_DONE : S_ACC;
          end
        end
        S_ACC: begin
          if (beat) begin
            acc <= sum_sat;
            cnt <= cnt - 1'b1;
            if (cnt == LEN_W'(1)) begin
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          // start in this state is ignored, even in the handshake cycle.
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef AP_ACC_SAT_FLAG_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_flag <= 1'b0;
    end else if ((state == S_IDLE) && start) begin
      sat_flag <= 1'b0;
    end else if (beat && (pos_ovf || neg_ovf)) begin
      sat_flag <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ap_accumulator.sv
module tb_ap_accumulator;

  localparam int W     = 68;
  localparam int LEN_W = 16;

  localparam logic [W-1:0] MAXV = 68'h7_FFFF_FFFF_FFFF_FFFF;
  localparam logic [W-1:0] MINV = 68'h8_0000_0000_0000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n     = 1'b0;
  logic             start     = 1'b0;
  logic [LEN_W-1:0] len       = '0;
  logic             in_valid  = 1'b0;
  logic [W-1:0]     in_data   = '0;
  logic             in_ready;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic             out_ready = 1'b0;
  logic             busy;
`ifdef AP_ACC_SAT_FLAG_EN
  logic             sat_flag;
`endif

  ap_accumulator #(.W(W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy)
`ifdef AP_ACC_SAT_FLAG_EN
    ,
    .sat_flag  (sat_flag)
`endif
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic         sat_q[$];
  logic [W-1:0] terms[8];

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: a handshake will occur on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1'b1, 1'b0);
      end else begin
        check("result", out_data, exp_q.pop_front());
`ifdef AP_ACC_SAT_FLAG_EN
        check("sat_flag", W'(sat_flag), W'(sat_q.pop_front()));
`else
        void'(sat_q.pop_front());
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int budget = 50;
    while (busy && budget > 0) begin
      tick();
      budget--;
    end
    if (busy) check("wait_idle_timeout", 1'b1, 1'b0);
  endtask

  task automatic start_job(input int n);
    start = 1'b1;
    len   = LEN_W'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic send_beats(input int n);
    for (int i = 0; i < n; i++) begin
      int budget = 20;
      in_valid = 1'b1;
      in_data  = terms[i];
      while (!in_ready && budget > 0) begin
        tick();
        budget--;
      end
      if (!in_ready) check("in_ready_timeout", 1'b1, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  // Full job: expected sum is pushed when the job is issued; the latency of
  // out_valid after the last beat is checked here.
  task automatic run_job(input string name, input int n,
                         input logic [W-1:0] sum, input logic sat);
    wait_idle();
    exp_q.push_back(sum);
    sat_q.push_back(sat);
    start_job(n);
    send_beats(n);
    check({name, "_latency"}, W'(out_valid), W'(1));
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_in_ready"},  W'(in_ready),  '0);
    check({name, "_out_valid"}, W'(out_valid), '0);
    check({name, "_out_data"},  out_data,      '0);
    check({name, "_busy"},      W'(busy),      '0);
`ifdef AP_ACC_SAT_FLAG_EN
    check({name, "_sat_flag"},  W'(sat_flag),  '0);
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] held;
    rst_n = 1'b0;
    repeat (2) tick();
    check_all_zero("reset");
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();

    // 1: 5 - 2 + 10 = 13
    terms[0] = 68'd5; terms[1] = -68'sd2; terms[2] = 68'd10;
    run_job("basic", 3, 68'd13, 1'b0);

    // 2: max + 1 clamps to max
    terms[0] = MAXV; terms[1] = 68'd1;
    run_job("pos_sat", 2, MAXV, 1'b1);

    // 3: min - 1 clamps to min, then +5 leaves the rail
    terms[0] = MINV; terms[1] = -68'sd1; terms[2] = 68'd5;
    run_job("neg_sat", 3, 68'h8_0000_0000_0000_0005, 1'b1);

    // negative sum without clamping: -3 + -4 = -7
    terms[0] = -68'sd3; terms[1] = -68'sd4;
    run_job("neg_sum", 2, 68'hF_FFFF_FFFF_FFFF_FFF9, 1'b0);

    // 4: len = 0, a presented term must not be consumed
    wait_idle();
    exp_q.push_back('0);
    sat_q.push_back(1'b0);
    in_valid = 1'b1;
    in_data  = 68'd99;
    start_job(0);
    check("len0_out_valid", W'(out_valid), W'(1));
    check("len0_in_ready",  W'(in_ready),  '0);
    tick();
    in_valid = 1'b0;

    // 5: hold in DONE for 4 cycles with start pulses
    wait_idle();
    out_ready = 1'b0;
    terms[0] = 68'd20; terms[1] = 68'd22;
    run_job("hold", 2, 68'd42, 1'b0);
    held = 68'd42;
    for (int i = 0; i < 4; i++) begin
      start = 1'b1;
      len   = LEN_W'(3);
      check("hold_out_valid", W'(out_valid), W'(1));
      check("hold_out_data",  out_data,      held);
      tick();
    end
    // Handshake with a simultaneous start: the start is ignored.
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    check("hs_busy", W'(busy), '0);
    tick();
    check("after_hs_busy",      W'(busy),      '0);
    check("after_hs_out_valid", W'(out_valid), '0);

    // 6: reset after 2 of 4 beats aborts the job
    terms[0] = 68'd1; terms[1] = 68'd2;
    start_job(4);
    send_beats(2);
    check("mid_busy", W'(busy), W'(1));
    rst_n = 1'b0;
    tick();
    check_all_zero("abort");
    rst_n = 1'b1;
    tick();
    terms[0] = 68'd7;
    run_job("after_abort", 1, 68'd7, 1'b0);

    // drain
    begin
      int budget = 50;
      while (exp_q.size() != 0 && budget > 0) begin
        tick();
        budget--;
      end
    end
    check("queue_empty", W'(exp_q.size()), '0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule
